// File: rtl/decode_hazard_stage.sv
// DLX decode stage: field split, register bank with WB bypass, load-use stall, ID/EX register.
// Optional DECODE_FORWARD_EN: MEM-stage result forwarded into operands instead of stalling.
module decode_hazard_stage #(
  parameter int PC_WIDTH          = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int IMEDIATE_WIDTH    = 16,
  parameter int PC_OFFSET_WIDTH   = 26
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_reg_in,
  input  logic [PC_WIDTH-1:0]          new_pc_in,
  input  logic                         valid_in,
  input  logic                         flush_in,
  input  logic                         ex_mem_read_in,
  input  logic [REG_ADDR_WIDTH-1:0]    ex_w_reg_addr_in,
  input  logic                         mem_fwd_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    mem_fwd_addr_in,
  input  logic [DATA_WIDTH-1:0]        mem_fwd_data_in,
  input  logic                         wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_write_addr,
  input  logic [DATA_WIDTH-1:0]        wb_write_data,
  output logic                         stall_out,
  output logic                         valid_out,
  output logic [5:0]                   opcode_out,
  output logic [10:0]                  inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
  output logic [REG_ADDR_WIDTH-1:0]    w_reg_addr_out,
  output logic                         w_reg_wr_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         alu_src_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic [DATA_WIDTH-1:0]        data_alu_a_out,
  output logic [DATA_WIDTH-1:0]        data_alu_b_out,
  output logic [DATA_WIDTH-1:0]        constant_out,
  output logic [PC_WIDTH-1:0]          new_pc_out,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset_out
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int SW_ = DATA_WIDTH - IMEDIATE_WIDTH;

  logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];

  logic [5:0]                w_op;
  logic [10:0]               w_funct;
  logic [REG_ADDR_WIDTH-1:0] w_rs1;
  logic [REG_ADDR_WIDTH-1:0] w_rs2;
  logic [REG_ADDR_WIDTH-1:0] w_rdr;
  logic [IMEDIATE_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0]     w_sext;

  assign w_op    = instruction_reg_in[IW-1 -: 6];
  assign w_funct = instruction_reg_in[10:0];
  assign w_rs1   = instruction_reg_in[21 +: REG_ADDR_WIDTH];
  assign w_rs2   = instruction_reg_in[16 +: REG_ADDR_WIDTH];
  assign w_rdr   = instruction_reg_in[11 +: REG_ADDR_WIDTH];
  assign w_imm   = instruction_reg_in[IMEDIATE_WIDTH-1:0];
  assign w_sext  = {{SW_{w_imm[IMEDIATE_WIDTH-1]}}, w_imm};

  logic w_op_r, w_op_lw, w_op_sw, w_op_br, w_op_jal, w_op_j;

  assign w_op_r   = (w_op == 6'h00);
  assign w_op_lw  = (w_op == 6'h23);
  assign w_op_sw  = (w_op == 6'h2B);
  assign w_op_br  = (w_op == 6'h04) || (w_op == 6'h05);
  assign w_op_jal = (w_op == 6'h03);
  assign w_op_j   = (w_op == 6'h02) || (w_op == 6'h12);

  logic                      w_wr_en, w_mem_wr, w_wb_sel;
  logic                      w_alu_src, w_branch, w_jump;
  logic                      w_use_rs2;
  logic [REG_ADDR_WIDTH-1:0] w_rd;

  always_comb begin
    w_wr_en   = 1'b1;
    w_mem_wr  = 1'b0;
    w_wb_sel  = 1'b0;
    w_alu_src = 1'b1;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_use_rs2 = 1'b0;
    w_rd      = w_rs2;
    unique case (1'b1)
      w_op_r: begin
        w_alu_src = 1'b0;
        w_use_rs2 = 1'b1;
        w_rd      = w_rdr;
      end
      w_op_lw: w_wb_sel = 1'b1;
      w_op_sw: begin
        w_wr_en   = 1'b0;
        w_mem_wr  = 1'b1;
        w_use_rs2 = 1'b1;
      end
      w_op_br: begin
        w_wr_en   = 1'b0;
        w_alu_src = 1'b0;
        w_branch  = 1'b1;
      end
      w_op_jal: begin
        w_alu_src = 1'b0;
        w_jump    = 1'b1;
        w_rd      = '1;
      end
      w_op_j: begin
        w_wr_en   = 1'b0;
        w_alu_src = 1'b0;
        w_jump    = 1'b1;
      end
      default: ;
    endcase
  end

  logic w_fwd1, w_fwd2, w_mem_haz;

`ifdef DECODE_FORWARD_EN
  assign w_fwd1    = mem_fwd_en_in && (mem_fwd_addr_in == w_rs1);
  assign w_fwd2    = mem_fwd_en_in && (mem_fwd_addr_in == w_rs2);
  assign w_mem_haz = 1'b0;
`else
  assign w_fwd1    = 1'b0;
  assign w_fwd2    = 1'b0;
  assign w_mem_haz = mem_fwd_en_in && (mem_fwd_addr_in != '0) &&
                     ((mem_fwd_addr_in == w_rs1) ||
                      (w_use_rs2 && (mem_fwd_addr_in == w_rs2)));
`endif

  logic w_lu_haz;

  assign w_lu_haz = ex_mem_read_in && (ex_w_reg_addr_in != '0) &&
                    ((ex_w_reg_addr_in == w_rs1) ||
                     (w_use_rs2 && (ex_w_reg_addr_in == w_rs2)));

  // Flush outranks stall so a killed instruction never freezes fetch.
  assign stall_out = rst_n && valid_in && !flush_in &&
                     (w_lu_haz || w_mem_haz);

  logic w_bubble;

  assign w_bubble = !valid_in || flush_in || stall_out;

  logic [DATA_WIDTH-1:0] w_a, w_b;

  always_comb begin
    w_a = r_bank[w_rs1];
    if (w_rs1 == '0)
      w_a = '0;
    else if (w_fwd1)
      w_a = mem_fwd_data_in;
    else if (wb_write_enable && (wb_write_addr == w_rs1))
      w_a = wb_write_data;
    w_b = r_bank[w_rs2];
    if (w_rs2 == '0)
      w_b = '0;
    else if (w_fwd2)
      w_b = mem_fwd_data_in;
    else if (wb_write_enable && (wb_write_addr == w_rs2))
      w_b = wb_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_bank[i] <= '0;
    end else if (wb_write_enable && (wb_write_addr != '0)) begin
      r_bank[wb_write_addr] <= wb_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out              <= 1'b0;
      opcode_out             <= '0;
      inst_function_out      <= '0;
      read_address1_out      <= '0;
      read_address2_out      <= '0;
      w_reg_addr_out         <= '0;
      w_reg_wr_en_out        <= 1'b0;
      mem_data_wr_en_out     <= 1'b0;
      write_back_mux_sel_out <= 1'b0;
      alu_src_out            <= 1'b0;
      branch_inst_out        <= 1'b0;
      jump_inst_out          <= 1'b0;
      data_alu_a_out         <= '0;
      data_alu_b_out         <= '0;
      constant_out           <= '0;
      new_pc_out             <= '0;
      pc_offset_out          <= '0;
    end else begin
      valid_out              <= !w_bubble;
      opcode_out             <= w_op;
      inst_function_out      <= w_funct;
      read_address1_out      <= w_rs1;
      read_address2_out      <= w_rs2;
      w_reg_addr_out         <= w_rd;
      w_reg_wr_en_out        <= w_wr_en && !w_bubble;
      mem_data_wr_en_out     <= w_mem_wr && !w_bubble;
      write_back_mux_sel_out <= w_wb_sel;
      alu_src_out            <= w_alu_src;
      branch_inst_out        <= w_branch && !w_bubble;
      jump_inst_out          <= w_jump && !w_bubble;
      data_alu_a_out         <= w_a;
      data_alu_b_out         <= w_b;
      constant_out           <= w_sext;
      new_pc_out             <= new_pc_in;
      pc_offset_out          <= instruction_reg_in[PC_OFFSET_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Bench for decode_hazard_stage: directed scenarios plus random traffic vs a register-file model.
module tb_decode_hazard_stage;

`ifdef DECODE_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_reg_in;
  logic [31:0] new_pc_in;
  logic        valid_in, flush_in, ex_mem_read_in;
  logic [4:0]  ex_w_reg_addr_in;
  logic        mem_fwd_en_in;
  logic [4:0]  mem_fwd_addr_in;
  logic [31:0] mem_fwd_data_in;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        stall_out, valid_out;
  logic [5:0]  opcode_out;
  logic [10:0] inst_function_out;
  logic [4:0]  read_address1_out, read_address2_out, w_reg_addr_out;
  logic        w_reg_wr_en_out, mem_data_wr_en_out;
  logic        write_back_mux_sel_out, alu_src_out;
  logic        branch_inst_out, jump_inst_out;
  logic [31:0] data_alu_a_out, data_alu_b_out, constant_out;
  logic [31:0] new_pc_out;
  logic [25:0] pc_offset_out;

  decode_hazard_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instruction_reg_in(instruction_reg_in),
    .new_pc_in(new_pc_in),
    .valid_in(valid_in), .flush_in(flush_in),
    .ex_mem_read_in(ex_mem_read_in),
    .ex_w_reg_addr_in(ex_w_reg_addr_in),
    .mem_fwd_en_in(mem_fwd_en_in),
    .mem_fwd_addr_in(mem_fwd_addr_in),
    .mem_fwd_data_in(mem_fwd_data_in),
    .wb_write_enable(wb_write_enable),
    .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data),
    .stall_out(stall_out), .valid_out(valid_out),
    .opcode_out(opcode_out),
    .inst_function_out(inst_function_out),
    .read_address1_out(read_address1_out),
    .read_address2_out(read_address2_out),
    .w_reg_addr_out(w_reg_addr_out),
    .w_reg_wr_en_out(w_reg_wr_en_out),
    .mem_data_wr_en_out(mem_data_wr_en_out),
    .write_back_mux_sel_out(write_back_mux_sel_out),
    .alu_src_out(alu_src_out),
    .branch_inst_out(branch_inst_out),
    .jump_inst_out(jump_inst_out),
    .data_alu_a_out(data_alu_a_out),
    .data_alu_b_out(data_alu_b_out),
    .constant_out(constant_out),
    .new_pc_out(new_pc_out),
    .pc_offset_out(pc_offset_out)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mregs [32];
  logic        last_stall;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (FWD_ON && mem_fwd_en_in && mem_fwd_addr_in == a)
      return mem_fwd_data_in;
    if (wb_write_enable && wb_write_addr == a) return wb_write_data;
    return mregs[a];
  endfunction

  task automatic clr();
    instruction_reg_in = '0; new_pc_in = '0;
    valid_in = 0; flush_in = 0;
    ex_mem_read_in = 0; ex_w_reg_addr_in = '0;
    mem_fwd_en_in = 0; mem_fwd_addr_in = '0;
    mem_fwd_data_in = '0;
    wb_write_enable = 0; wb_write_addr = '0;
    wb_write_data = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_op"}, opcode_out, 0);
    chk({tag, "_rd"}, w_reg_addr_out, 0);
    chk({tag, "_wren"}, w_reg_wr_en_out, 0);
    chk({tag, "_a"}, data_alu_a_out, 0);
    chk({tag, "_b"}, data_alu_b_out, 0);
    chk({tag, "_k"}, constant_out, 0);
    chk({tag, "_pc"}, new_pc_out, 0);
    chk({tag, "_off"}, pc_offset_out, 0);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, e_rd;
    logic [31:0] busy, e_a, e_b, e_k;
    logic        is_r, is_sw, is_lw, is_br, is_jmp;
    logic        e_stall, e_valid, e_wr;
    #1;
    op     = instruction_reg_in[31:26];
    rs1    = instruction_reg_in[25:21];
    rs2    = instruction_reg_in[20:16];
    is_r   = (op == 6'h00);
    is_sw  = (op == 6'h2B);
    is_lw  = (op == 6'h23);
    is_br  = (op == 6'h04) || (op == 6'h05);
    is_jmp = (op == 6'h02) || (op == 6'h03) || (op == 6'h12);
    busy = '0;
    if (ex_mem_read_in && ex_w_reg_addr_in != 0)
      busy[ex_w_reg_addr_in] = 1'b1;
    if (!FWD_ON && mem_fwd_en_in && mem_fwd_addr_in != 0)
      busy[mem_fwd_addr_in] = 1'b1;
    e_stall = valid_in && !flush_in &&
              (busy[rs1] || ((is_r || is_sw) && busy[rs2]));
    e_valid = valid_in && !flush_in && !e_stall;
    e_wr = !(is_sw || is_br || is_jmp) || (op == 6'h03);
    e_rd = is_r ? instruction_reg_in[15:11] :
           (op == 6'h03) ? 5'd31 : rs2;
    e_k  = {{16{instruction_reg_in[15]}}, instruction_reg_in[15:0]};
    e_a  = src_val(rs1);
    e_b  = src_val(rs2);
    last_stall = stall_out;
    chk("stall", stall_out, e_stall);
    @(posedge clk);
    if (wb_write_enable && wb_write_addr != 0)
      mregs[wb_write_addr] = wb_write_data;
    #1;
    chk("valid", valid_out, e_valid);
    chk("wren", w_reg_wr_en_out, e_valid && e_wr);
    chk("memwr", mem_data_wr_en_out, e_valid && is_sw);
    chk("branch", branch_inst_out, e_valid && is_br);
    chk("jump", jump_inst_out, e_valid && is_jmp);
    if (e_valid) begin
      chk("op", opcode_out, op);
      chk("funct", inst_function_out, instruction_reg_in[10:0]);
      chk("rs1", read_address1_out, rs1);
      chk("rs2", read_address2_out, rs2);
      chk("rd", w_reg_addr_out, e_rd);
      chk("wbsel", write_back_mux_sel_out, is_lw);
      if (!is_br && !is_jmp) chk("alusrc", alu_src_out, !is_r);
      chk("a", data_alu_a_out, e_a);
      chk("b", data_alu_b_out, e_b);
      chk("const", constant_out, e_k);
      chk("pc", new_pc_out, new_pc_in);
      chk("off", pc_offset_out, instruction_reg_in[25:0]);
    end
    @(negedge clk);
  endtask

  task automatic rand_in();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B;
      3: op = 6'h04; 4: op = 6'h05; 5: op = 6'h02;
      6: op = 6'h03; 7: op = 6'h12; 8: op = 6'h08;
      default: op = 6'($urandom);
    endcase
    instruction_reg_in = {op, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom), 11'($urandom)};
    new_pc_in        = $urandom;
    valid_in         = ($urandom_range(0, 99) < 85);
    flush_in         = ($urandom_range(0, 99) < 10);
    ex_mem_read_in   = ($urandom_range(0, 99) < 35);
    ex_w_reg_addr_in = 5'($urandom_range(0, 7));
    mem_fwd_en_in    = ($urandom_range(0, 99) < 35);
    mem_fwd_addr_in  = 5'($urandom_range(0, 7));
    mem_fwd_data_in  = $urandom;
    wb_write_enable  = ($urandom_range(0, 99) < 50);
    wb_write_addr    = 5'($urandom_range(0, 7));
    wb_write_data    = $urandom;
  endtask

  task automatic do_reset(input string tag);
    valid_in = 1;
    instruction_reg_in = {6'h00, 5'd4, 5'd2, 5'd1, 11'h020};
    ex_mem_read_in = 1; ex_w_reg_addr_in = 5'd4;
    rst_n = 0;
    #1;
    chk_zero(tag);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    clr();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    clr();
    rst_n = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst_n = 1;
    clr();

    // WB bypass into same-cycle decode
    wb_write_enable = 1; wb_write_addr = 5'd5;
    wb_write_data = 32'h1234; valid_in = 1;
    instruction_reg_in = {6'h00, 5'd5, 5'd6, 5'd3, 11'h020};
    step();
    chk("byp_a", data_alu_a_out, 32'h1234);

    // load-use: one stall bubble, then the ADD
    clr(); valid_in = 1;
    instruction_reg_in = {6'h00, 5'd4, 5'd2, 5'd1, 11'h020};
    ex_mem_read_in = 1; ex_w_reg_addr_in = 5'd4;
    step();
    chk("lu_stall", last_stall, 1);
    chk("lu_bubble", valid_out, 0);
    ex_mem_read_in = 0;
    step();
    chk("lu_go", valid_out, 1);
    chk("lu_rs1", read_address1_out, 5'd4);

    // negative immediate, then r0 write ignored
    clr(); valid_in = 1;
    instruction_reg_in = {6'h08, 5'd0, 5'd2, 16'hFFFE};
    step();
    chk("imm_k", constant_out, 32'hFFFFFFFE);
    chk("imm_src", alu_src_out, 1);
    wb_write_enable = 1; wb_write_addr = 5'd0;
    wb_write_data = 32'hDEAD;
    instruction_reg_in = {6'h00, 5'd0, 5'd0, 5'd1, 11'h020};
    step();
    chk("r0_byp", data_alu_a_out, 0);
    wb_write_enable = 0;
    step();
    chk("r0_read", data_alu_a_out, 0);

    // flush wins over a concurrent load-use
    clr(); valid_in = 1; flush_in = 1;
    instruction_reg_in = {6'h00, 5'd4, 5'd2, 5'd1, 11'h020};
    ex_mem_read_in = 1; ex_w_reg_addr_in = 5'd4;
    step();
    chk("fl_stall", last_stall, 0);
    chk("fl_valid", valid_out, 0);

    // MEM-stage writer of r7 then retiring through WB
    clr(); valid_in = 1;
    instruction_reg_in = {6'h00, 5'd7, 5'd0, 5'd1, 11'h022};
    mem_fwd_en_in = 1; mem_fwd_addr_in = 5'd7;
    mem_fwd_data_in = 32'hBEEF;
    step();
`ifdef DECODE_FORWARD_EN
    chk("mf_stall", last_stall, 0);
    chk("mf_a", data_alu_a_out, 32'hBEEF);
`else
    chk("mf_stall", last_stall, 1);
    chk("mf_bubble", valid_out, 0);
`endif
    mem_fwd_en_in = 0;
    wb_write_enable = 1; wb_write_addr = 5'd7;
    wb_write_data = 32'hBEEF;
    step();
    chk("mf_wb_a", data_alu_a_out, 32'hBEEF);
    clr();

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset("midrst");
      rand_in();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
